// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall, bubble insertion and flush.
// Priority per edge: flush > hold (en=0) > bubble > load. out_valid=1 means the stage holds a real instruction.
module pipe_stage_reg #(
    parameter int              DATA_W   = 128,
    parameter int              PC_W     = 32,
    parameter int              TNEW_W   = 4,
    parameter int              CNT_W    = 16,
    parameter logic [PC_W-1:0] FLUSH_PC = PC_W'(32'h0000_4180)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              bubble,
    input  logic              flush,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [31:0]       in_instr,
    input  logic              in_bd,
    input  logic [4:0]        in_exc,
    input  logic              in_wen,
    input  logic [4:0]        in_a3,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [DATA_W-1:0] in_payload,
    output logic [PC_W-1:0]   out_pc,
    output logic [31:0]       out_instr,
    output logic              out_bd,
    output logic [4:0]        out_exc,
    output logic              out_wen,
    output logic [4:0]        out_a3,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [DATA_W-1:0] out_payload,
    output logic              out_valid,
    output logic              out_wen_eff,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_instr;
    logic              r_bd;
    logic [4:0]        r_exc;
    logic              r_wen;
    logic [4:0]        r_a3;
    logic [TNEW_W-1:0] r_tnew;
    logic [DATA_W-1:0] r_payload;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic [TNEW_W-1:0] w_tnew_dec;
    logic              w_cnt_full;

    // Tnew counts down one stage; it never wraps below zero.
    assign w_tnew_dec = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
    assign w_cnt_full = &r_bubble_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= '0;
            r_instr      <= '0;
            r_bd         <= 1'b0;
            r_exc        <= '0;
            r_wen        <= 1'b0;
            r_a3         <= '0;
            r_tnew       <= '0;
            r_payload    <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_pc         <= FLUSH_PC;
            r_instr      <= '0;
            r_bd         <= 1'b0;
            r_exc        <= '0;
            r_wen        <= 1'b0;
            r_a3         <= '0;
            r_tnew       <= '0;
            r_payload    <= '0;
            r_valid      <= 1'b0;
        end else if (en) begin
            if (bubble) begin
                // PC and delay-slot flag survive so a later exception still reports the right EPC.
                r_pc         <= in_pc;
                r_instr      <= '0;
                r_bd         <= in_bd;
                r_exc        <= '0;
                r_wen        <= 1'b0;
                r_a3         <= '0;
                r_tnew       <= '0;
                r_payload    <= '0;
                r_valid      <= 1'b0;
                if (!w_cnt_full) begin
                    r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
                end
            end else begin
                r_pc         <= in_pc;
                r_instr      <= in_instr;
                r_bd         <= in_bd;
                r_exc        <= in_exc;
                r_wen        <= in_wen;
                r_a3         <= in_a3;
                r_tnew       <= w_tnew_dec;
                r_payload    <= in_payload;
                r_valid      <= 1'b1;
            end
        end
    end

    assign out_pc      = r_pc;
    assign out_instr   = r_instr;
    assign out_bd      = r_bd;
    assign out_exc     = r_exc;
    assign out_wen     = r_wen;
    assign out_a3      = r_a3;
    assign out_tnew    = r_tnew;
    assign out_payload = r_payload;
    assign out_valid   = r_valid;
    assign bubble_cnt  = r_bubble_cnt;
    assign out_wen_eff = r_wen & r_valid & (r_a3 != 5'd0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a driver pushes model predictions, a monitor pops and compares after each edge.
module tb_pipe_stage_reg;

  localparam int DATA_W = 128;
  localparam int PC_W = 32;
  localparam int TNEW_W = 4;
  localparam int CNT_W = 16;
  localparam logic [31:0] FLUSH_PC = 32'h0000_4180;
  localparam int OUT_W = PC_W + 32 + 1 + 5 + 1 + 5 + TNEW_W + DATA_W + 1 + 1 + CNT_W + 2;

  logic clk, reset, en, bubble, flush;
  logic [PC_W-1:0] in_pc;
  logic [31:0] in_instr;
  logic in_bd;
  logic [4:0] in_exc;
  logic in_wen;
  logic [4:0] in_a3;
  logic [TNEW_W-1:0] in_tnew;
  logic [DATA_W-1:0] in_payload;

  logic [PC_W-1:0] out_pc;
  logic [31:0] out_instr;
  logic out_bd;
  logic [4:0] out_exc;
  logic out_wen;
  logic [4:0] out_a3;
  logic [TNEW_W-1:0] out_tnew;
  logic [DATA_W-1:0] out_payload;
  logic out_valid, out_wen_eff;
  logic [CNT_W-1:0] bubble_cnt;

  // second instance with a 2-bit counter for saturation
  logic [PC_W-1:0] s_pc;
  logic [31:0] s_instr;
  logic s_bd;
  logic [4:0] s_exc;
  logic s_wen;
  logic [4:0] s_a3;
  logic [TNEW_W-1:0] s_tnew;
  logic [DATA_W-1:0] s_payload;
  logic s_valid, s_wen_eff;
  logic [1:0] s_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .TNEW_W(TNEW_W), .CNT_W(CNT_W), .FLUSH_PC(FLUSH_PC)) dut (
    .clk(clk), .reset(reset), .en(en), .bubble(bubble), .flush(flush),
    .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd), .in_exc(in_exc), .in_wen(in_wen),
    .in_a3(in_a3), .in_tnew(in_tnew), .in_payload(in_payload),
    .out_pc(out_pc), .out_instr(out_instr), .out_bd(out_bd), .out_exc(out_exc), .out_wen(out_wen),
    .out_a3(out_a3), .out_tnew(out_tnew), .out_payload(out_payload), .out_valid(out_valid),
    .out_wen_eff(out_wen_eff), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .TNEW_W(TNEW_W), .CNT_W(2), .FLUSH_PC(FLUSH_PC)) dut_s (
    .clk(clk), .reset(reset), .en(en), .bubble(bubble), .flush(flush),
    .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd), .in_exc(in_exc), .in_wen(in_wen),
    .in_a3(in_a3), .in_tnew(in_tnew), .in_payload(in_payload),
    .out_pc(s_pc), .out_instr(s_instr), .out_bd(s_bd), .out_exc(s_exc), .out_wen(s_wen),
    .out_a3(s_a3), .out_tnew(s_tnew), .out_payload(s_payload), .out_valid(s_valid),
    .out_wen_eff(s_wen_eff), .bubble_cnt(s_cnt)
  );

  logic [OUT_W-1:0] w_act;
  assign w_act = {out_pc, out_instr, out_bd, out_exc, out_wen, out_a3, out_tnew, out_payload,
                  out_valid, out_wen_eff, bubble_cnt, s_cnt};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state: architectural view of the stage plus a plain bubble tally
  logic [PC_W-1:0] m_pc;
  logic [31:0] m_instr;
  logic m_bd;
  logic [4:0] m_exc;
  logic m_wen;
  logic [4:0] m_a3;
  logic [TNEW_W-1:0] m_tnew;
  logic [DATA_W-1:0] m_payload;
  logic m_valid;
  int n_bub;

  logic [OUT_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [OUT_W-1:0] model_vec();
    logic weff;
    logic [CNT_W-1:0] c;
    logic [1:0] cs;
    weff = m_wen && m_valid && (m_a3 != 5'd0);
    c = (n_bub > 65535) ? CNT_W'(65535) : CNT_W'(n_bub);
    cs = (n_bub > 3) ? 2'd3 : 2'(n_bub);
    return {m_pc, m_instr, m_bd, m_exc, m_wen, m_a3, m_tnew, m_payload, m_valid, weff, c, cs};
  endfunction

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_bd = 1'b0; m_exc = '0; m_wen = 1'b0;
    m_a3 = '0; m_tnew = '0; m_payload = '0; m_valid = 1'b0; n_bub = 0;
  endtask

  task automatic model_clear(input logic [PC_W-1:0] pc, input logic bd);
    m_pc = pc; m_instr = '0; m_bd = bd; m_exc = '0; m_wen = 1'b0;
    m_a3 = '0; m_tnew = '0; m_payload = '0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    int t;
    if (flush) begin
      model_clear(FLUSH_PC, 1'b0);
    end else if (!en) begin
      // stall: nothing changes
    end else if (bubble) begin
      model_clear(in_pc, in_bd);
      n_bub = n_bub + 1;
    end else begin
      t = int'(in_tnew) - 1;
      if (t < 0) t = 0;
      m_pc = in_pc; m_instr = in_instr; m_bd = in_bd; m_exc = in_exc; m_wen = in_wen;
      m_a3 = in_a3; m_tnew = TNEW_W'(t); m_payload = in_payload; m_valid = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: called at a negedge, leave at the next negedge
  task automatic set_idle();
    en = 1'b1; bubble = 1'b0; flush = 1'b0;
    in_pc = '0; in_instr = '0; in_bd = 1'b0; in_exc = '0; in_wen = 1'b0;
    in_a3 = '0; in_tnew = '0; in_payload = '0;
  endtask

  task automatic cycle();
    model_step();
    exp_q.push_back(model_vec());
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    en = ($urandom_range(0, 9) != 0);
    bubble = ($urandom_range(0, 3) == 0);
    flush = ($urandom_range(0, 15) == 0);
    in_pc = $urandom;
    in_instr = $urandom;
    in_bd = 1'($urandom_range(0, 1));
    in_exc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
    in_wen = 1'($urandom_range(0, 1));
    in_a3 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    in_tnew = TNEW_W'($urandom_range(0, 15));
    in_payload = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // monitor: the stage presents a new output after every rising edge
  always @(posedge clk) begin
    logic [OUT_W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", w_act, e);
    end
  end

  initial begin
    reset = 1'b0;
    set_idle();
    randomize_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", w_act, '0);
    reset = 1'b1;
    set_idle();

    // load
    in_pc = 32'h3000; in_a3 = 5'd5; in_wen = 1'b1; in_tnew = 4'd2;
    cycle();
    check("load_pc", OUT_W'(out_pc), OUT_W'(32'h3000));
    check("load_tnew", OUT_W'(out_tnew), OUT_W'(1));
    check("load_valid_weff", OUT_W'({out_valid, out_wen_eff}), OUT_W'(2'b11));

    // tnew saturation and $0 destination
    in_tnew = 4'd0; in_a3 = 5'd0; in_wen = 1'b1;
    cycle();
    check("tnew_sat", OUT_W'(out_tnew), OUT_W'(0));
    check("weff_a3_zero", OUT_W'(out_wen_eff), OUT_W'(0));

    // bubble with EPC preservation, then counter saturation on the 2-bit instance
    set_idle();
    bubble = 1'b1; in_pc = 32'h3004; in_bd = 1'b1; in_wen = 1'b1; in_a3 = 5'd7;
    cycle();
    check("bubble_pc", OUT_W'(out_pc), OUT_W'(32'h3004));
    check("bubble_flags", OUT_W'({out_bd, out_valid, out_wen}), OUT_W'(3'b100));
    check("bubble_cnt1", OUT_W'(bubble_cnt), OUT_W'(1));
    repeat (4) cycle();
    check("bubble_cnt5", OUT_W'(bubble_cnt), OUT_W'(5));
    check("small_cnt_sat", OUT_W'(s_cnt), OUT_W'(3));

    // hold beats bubble
    set_idle();
    in_pc = 32'h5000; in_a3 = 5'd9; in_wen = 1'b1; in_tnew = 4'd3;
    cycle();
    en = 1'b0; bubble = 1'b1; in_pc = 32'h6000;
    cycle();
    check("hold_pc", OUT_W'(out_pc), OUT_W'(32'h5000));
    check("hold_valid_cnt", OUT_W'({out_valid, bubble_cnt}), OUT_W'({1'b1, 16'd5}));

    // flush beats hold and bubble
    flush = 1'b1;
    cycle();
    check("flush_pc", OUT_W'(out_pc), OUT_W'(FLUSH_PC));
    check("flush_valid_cnt", OUT_W'({out_valid, bubble_cnt}), OUT_W'({1'b0, 16'd5}));

    // asynchronous reset between edges
    set_idle();
    in_pc = 32'h7000; in_a3 = 5'd3; in_wen = 1'b1;
    cycle();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset", w_act, '0);
    @(posedge clk);
    #1;
    check("reset_held", w_act, '0);
    @(negedge clk);
    reset = 1'b1;
    in_pc = 32'h7004;
    cycle();
    check("post_reset_load", OUT_W'({out_valid, out_pc}), OUT_W'({1'b1, 32'h7004}));

    // randomized traffic with occasional resets
    repeat (400) begin
      if ($urandom_range(0, 49) == 0) begin
        randomize_inputs();
        reset = 1'b0;
        model_reset();
        #1;
        check("rand_reset", w_act, '0);
        @(negedge clk);
        reset = 1'b1;
      end else begin
        randomize_inputs();
        cycle();
      end
    end

    set_idle();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
